// File: rtl/sequenciador_3b_pkg.sv
// rtl/sequenciador_3b_pkg.sv - shared types and constants for the 3-bit scan sequencer
package seq_pkg;

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] TERM_HI = 3'd7;
  localparam logic [SEL_W-1:0] TERM_LO = 3'd0;

  function automatic logic [SEL_W-1:0] wrap_next(input logic [SEL_W-1:0] v, input logic up);
    return up ? v + 3'd1 : v - 3'd1;
  endfunction

endpackage

// File: rtl/sequenciador_3b_if.sv
// rtl/sequenciador_3b_if.sv - control inputs and select/terminal-count outputs of the sequencer
interface sequenciador_3b_if;

  logic       en;
  logic       step;
  logic       dir;
  logic       mode;
  logic       load;
  logic [2:0] load_val;
  logic       A;
  logic       B;
  logic       C;
  logic       tc;

  modport master (
    output en, step, dir, mode, load, load_val,
    input  A, B, C, tc
  );

  modport slave (
    input  en, step, dir, mode, load, load_val,
    output A, B, C, tc
  );

endinterface

// File: rtl/sequenciador_3b_divisor_tick.sv
// rtl/sequenciador_3b_divisor_tick.sv - prescaler producing one strobe every DIV cycles while running
module divisor_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic strobe
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;

  assign strobe = run && (cnt_q == LAST);

  // Leaving RUN or loading restarts the period so no partial step survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || !run || strobe) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/sequenciador_3b.sv
// rtl/sequenciador_3b.sv - registered 3-bit scan sequencer (wrap, optional ping-pong via SEQ_PINGPONG_EN)
module sequenciador_3b
  import seq_pkg::*;
#(
  parameter int               DIV   = 4,
  parameter logic [SEL_W-1:0] START = 3'd0
) (
  input logic               clk,
  input logic               rst_n,
  sequenciador_3b_if.slave  bus
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             strobe;
  logic             step_en;
`ifdef SEQ_PINGPONG_EN
  logic             pp_q, pp_d;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.en)  state_d = ST_RUN;
      ST_RUN:  if (!bus.en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  divisor_tick #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (state_q == ST_RUN),
    .clr    (bus.load),
    .strobe (strobe)
  );

  // The external step request only counts while idle.
  assign step_en = (state_q == ST_RUN) ? strobe : bus.step;

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
`ifdef SEQ_PINGPONG_EN
    pp_d  = pp_q;
`endif
    if (bus.load) begin
      cnt_d = bus.load_val;
`ifdef SEQ_PINGPONG_EN
      pp_d  = bus.dir;
`endif
    end else if (step_en) begin
`ifdef SEQ_PINGPONG_EN
      if (bus.mode) begin
        // Endpoints turn around without repeating the terminal value.
        if (pp_q) begin
          if (cnt_q == TERM_HI) begin
            cnt_d = TERM_HI - 3'd1;
            pp_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else begin
          if (cnt_q == TERM_LO) begin
            cnt_d = TERM_LO + 3'd1;
            pp_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        tc_d = (cnt_d == TERM_HI) || (cnt_d == TERM_LO);
      end else begin
        cnt_d = wrap_next(cnt_q, bus.dir);
        tc_d  = bus.dir ? (cnt_d == TERM_HI) : (cnt_d == TERM_LO);
      end
`else
      cnt_d = wrap_next(cnt_q, bus.dir);
      tc_d  = bus.dir ? (cnt_d == TERM_HI) : (cnt_d == TERM_LO);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= START;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
    end
  end

`ifdef SEQ_PINGPONG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pp_q <= 1'b1;
    end else begin
      pp_q <= pp_d;
    end
  end
`endif

  assign bus.A  = cnt_q[2];
  assign bus.B  = cnt_q[1];
  assign bus.C  = cnt_q[0];
  assign bus.tc = tc_q;

endmodule

// File: tb/tb_sequenciador_3b.sv
// tb/tb_sequenciador_3b.sv - directed self-checking bench for sequenciador_3b
module tb_sequenciador_3b;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  sequenciador_3b_if s4();
  sequenciador_3b_if s1();

  sequenciador_3b #(.DIV(4), .START(3'd0)) u4 (.clk(clk), .rst_n(rst_n), .bus(s4));
  sequenciador_3b #(.DIV(1), .START(3'd0)) u1 (.clk(clk), .rst_n(rst_n), .bus(s1));

`ifdef SEQ_PINGPONG_EN
  localparam int PN = 10;
  logic [2:0] pp_val [PN] = '{3'd6, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};
  logic       pp_tc  [PN] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
  localparam int PN = 5;
  logic [2:0] pp_val [PN] = '{3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
  logic       pp_tc  [PN] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] v4();
    return {s4.A, s4.B, s4.C};
  endfunction

  function automatic logic [2:0] v1();
    return {s1.A, s1.B, s1.C};
  endfunction

  // Assumes the DIV=4 prescaler is at zero in RUN on entry.
  task automatic step4(input string tag, input logic [2:0] prev, input logic [2:0] nxt, input logic tce);
    repeat (3) begin
      tick();
      chk({tag, "_hold"}, v4(), prev);
      chk({tag, "_hold_tc"}, s4.tc, 1'b0);
    end
    tick();
    chk(tag, v4(), nxt);
    chk({tag, "_tc"}, s4.tc, tce);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    s4.en = 0; s4.step = 0; s4.dir = 1; s4.mode = 0; s4.load = 0; s4.load_val = 3'd0;
    s1.en = 0; s1.step = 0; s1.dir = 1; s1.mode = 0; s1.load = 0; s1.load_val = 3'd0;
    tick();
    tick();
    chk("reset_val", v4(), 3'd0);
    chk("reset_tc", s4.tc, 1'b0);
    rst_n = 1'b1;

    // Free-run up, DIV=4
    s4.en = 1; s4.dir = 1;
    tick();
    chk("run_entry", v4(), 3'd0);
    for (int i = 1; i <= 8; i++) begin
      step4($sformatf("run_up_%0d", i), 3'(i - 1), 3'(i), i == 7);
    end

    // Load with a strobe due wins over the step
    repeat (3) tick();
    s4.load = 1; s4.load_val = 3'd6;
    tick();
    chk("load6", v4(), 3'd6);
    s4.load = 0;
    repeat (3) tick();
    s4.load = 1; s4.load_val = 3'd3;
    tick();
    chk("load_over_step", v4(), 3'd3);
    chk("load_over_step_tc", s4.tc, 1'b0);
    s4.load = 0;
    step4("after_load", 3'd3, 3'd4, 1'b0);
    step4("to5", 3'd4, 3'd5, 1'b0);
    step4("to6", 3'd5, 3'd6, 1'b0);

    // Asynchronous reset mid-sweep
    tick();
    rst_n = 1'b0;
    #1;
    chk("async_rst_val", v4(), 3'd0);
    chk("async_rst_tc", s4.tc, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_entry", v4(), 3'd0);
    step4("post_rst", 3'd0, 3'd1, 1'b0);

    // en dropped two cycles into a period
    tick();
    tick();
    s4.en = 0;
    tick();
    chk("drop_a", v4(), 3'd1);
    tick();
    chk("drop_b", v4(), 3'd1);
    s4.en = 1;
    tick();
    chk("reentry", v4(), 3'd1);
    step4("reentry_step", 3'd1, 3'd2, 1'b0);

    // Idle single steps, down
    s4.en = 0; s4.dir = 0;
    tick();
    chk("idle_enter", v4(), 3'd2);
    s4.step = 1;
    tick();
    chk("istep1", v4(), 3'd1);
    chk("istep1_tc", s4.tc, 1'b0);
    s4.step = 0;
    tick();
    chk("istep_gap", v4(), 3'd1);
    s4.step = 1;
    tick();
    chk("istep2", v4(), 3'd0);
    chk("istep2_tc", s4.tc, 1'b1);
    s4.step = 0;
    tick();
    chk("istep_gap_tc", s4.tc, 1'b0);
    s4.step = 1;
    tick();
    chk("istep3", v4(), 3'd7);
    chk("istep3_tc", s4.tc, 1'b0);
    s4.step = 0;

    // Sweep on the DIV=1 instance
    s1.load = 1; s1.load_val = 3'd5; s1.dir = 1; s1.mode = 1;
    tick();
    chk("pp_load", v1(), 3'd5);
    s1.load = 0; s1.en = 1;
    tick();
    chk("pp_entry", v1(), 3'd5);
    for (int i = 0; i < PN; i++) begin
      tick();
      chk($sformatf("pp_val_%0d", i), v1(), pp_val[i]);
      chk($sformatf("pp_tc_%0d", i), s1.tc, pp_tc[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sequenciador_3b.md
# sequenciador_3b

Registered 3-bit scan sequencer that produces the select lines A, B, C for the downstream 3-to-8 decoder, stepping through output lines 0..7. A programmable prescaler sets the step rate. The block supports free-run, single-step, synchronous load, up/down direction and an optional ping-pong sweep. A terminal-count pulse lets the surrounding logic count full sweeps.

## Interface
- DIV, 4: clock cycles per step in RUN; legal range 1..255.
- START, 3'd0: value of {A,B,C} after reset.
- clk  input  1  rising-edge clock, single domain.
- rst_n  input  1  reset, asynchronous assert, active-low; all registers clear immediately.
- en  input  1  1 = RUN (periodic stepping), 0 = IDLE.
- step  input  1  single-step request; honoured only in IDLE.
- dir  input  1  1 = up (+1), 0 = down (−1).
- mode  input  1  1 = ping-pong sweep, 0 = wrap; see Configuration.
- load  input  1  synchronous load of load_val.
- load_val  input  3  value loaded into {A,B,C}.
- A, B, C  output  1 each  registered select; A = MSB, C = LSB.
- tc  output  1  one-cycle pulse when the count lands on a terminal value.

## Operation
- Reset values: {A,B,C} = START, tc = 0, prescaler = 0, state = IDLE, ping-pong direction register pp = up.
- FSM, two states:
  - IDLE → RUN when en = 1.
  - RUN → IDLE when en = 0.
- Prescaler: counts 0..DIV−1 in RUN only; cleared in IDLE and on load. Step strobe = RUN and prescaler == DIV−1. Prescaler wraps to 0 on the strobe.
- Step sources: prescaler strobe in RUN, or step = 1 in IDLE (one step per cycle step is high). step in RUN is ignored.
- Priority, highest first: rst_n, load, step source. load: {A,B,C} ← load_val, pp ← dir, tc = 0, no step that cycle.
- Wrap mode (mode = 0):
  - Up: 7 → 0.
  - Down: 0 → 7.
  - Arithmetic is modulo 8.
  - tc = 1 when the new value is 7 (up) or 0 (down).
- Ping-pong mode (mode = 1):
  - Effective direction = pp. At 7 while going up, next value is 6 and pp flips to down; at 0 the mirror case applies.
  - No value repeats at the endpoints: the sequence from 0 is 0..7,6..1,0,1..
  - tc = 1 whenever the new value is 7 or 0.
- Mode or dir changes during RUN take effect on the next step. The prescaler phase is not disturbed.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- en 0→1 sampled at edge k: state is RUN from k. The first step is visible after edge k+DIV.
- Steady RUN: one step every DIV cycles. DIV = 1 steps every cycle.
- IDLE step sampled at edge k: new value visible after edge k. tc is valid in the same cycle as the value it flags.
- load sampled at edge k: load_val is visible after edge k. With en held high, the next step follows DIV cycles later.
- rst_n low mid-sweep: outputs return to reset values asynchronously. The first step after release needs en plus DIV cycles.
- en drop mid-period: the prescaler clears and no partial step occurs. Re-entering RUN starts a fresh DIV period.

## Configuration
- SEQ_PINGPONG_EN defined: the mode input, the pp register and the ping-pong tc rule are present, as described above.
- SEQ_PINGPONG_EN undefined: the mode input is ignored and treated as 0, the pp register is removed, and the sequencer only wraps.

## Structure
- Package seq_pkg:
  - State enum {ST_IDLE, ST_RUN}.
  - SEL_W = 3, TERM_HI = 3'd7, TERM_LO = 3'd0.
- Sub-module divisor_tick: parameter DIV; inputs clk, rst_n, run, clr; output strobe. It holds the prescaler counter and its width.
- The sequencer owns the FSM, the count/pp registers and the tc logic.

## Test plan
- Reset with START = 0, then en = 1, dir = 1, DIV = 4 → {A,B,C} steps 1,2,..,7,0 every 4 cycles. tc pulses once when the count reaches 7 and stays low at 0.
- IDLE, dir = 0, three one-cycle step pulses from 3'd2 → values 1, 0, 7. tc is high on the cycle showing 0 only.
- Ping-pong, DIV = 1, load_val = 5, dir = 1 → sequence 5,6,7,6,5..0,1. tc on 7 and on 0. Repeat build without SEQ_PINGPONG_EN → 5,6,7,0,1.
- load = 1 with en = 1 and a strobe due in the same cycle → load_val wins, no step, tc = 0. The next step comes 4 cycles later.
- rst_n pulsed low mid-sweep at value 6 → outputs return to START and tc = 0 immediately. After release with en = 1 the first step comes DIV cycles later.
- en dropped two cycles into a DIV = 4 period, then raised → no step during the drop. The next step comes exactly 4 cycles after en returns.
